// File: rtl/codec_i2s_dac_tx.sv
// rtl/codec_i2s_dac_tx.sv - I2S master DAC transmitter with a one-entry sample holding register
// Define I2S_REPEAT_ON_UNDERRUN_EN to repeat the last loaded pair on underrun instead of muting.
module codec_i2s_dac_tx #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 16,
  parameter int BCLK_DIV = 16
) (
  input  logic              clk_50mhz,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              cf_done_i,
  input  logic              smp_valid_i,
  output logic              smp_ready_o,
  input  logic [DATA_W-1:0] smp_left_i,
  input  logic [DATA_W-1:0] smp_right_i,
  output logic              aud_bclk_o,
  output logic              aud_daclrck_o,
  output logic              aud_dacdat_o,
  output logic              frame_start_o,
  output logic              underrun_o
);
  localparam int FW = 2 * SLOT_W;
  localparam int KW = $clog2(FW);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [KW-1:0] K_LAST   = KW'(FW - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t r_state, w_state_nxt;

  logic [DW-1:0]     r_div;
  logic [KW-1:0]     r_k;
  logic [FW-1:0]     r_shift;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold_l, r_hold_r;
  logic              w_run, w_stay, w_tick, w_fall, w_k0, w_xfer, w_bypass, w_underrun;
  logic [KW-1:0]     w_k_nxt;
  logic [FW-1:0]     w_frame;

  // Left-justify each sample in its slot; frame MSB is the left-channel MSB.
  function automatic logic [FW-1:0] pack(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    logic [SLOT_W-1:0] sl, sr;
    sl = SLOT_W'(l) << (SLOT_W - DATA_W);
    sr = SLOT_W'(r) << (SLOT_W - DATA_W);
    return {sl, sr};
  endfunction

  always_ff @(posedge clk_50mhz or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en_i && cf_done_i) w_state_nxt = S_RUN;
      S_RUN:   if (!(en_i && cf_done_i)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_run       = (r_state == S_RUN);
  assign w_stay      = w_run && en_i && cf_done_i;
  assign w_tick      = w_stay && (r_div == DIV_LAST);
  assign w_fall      = w_tick && aud_bclk_o;
  assign w_k_nxt     = (r_k == K_LAST) ? '0 : r_k + KW'(1);
  assign w_k0        = w_fall && (r_k == K_LAST);
  assign smp_ready_o = w_run && !r_hold_full;
  assign w_xfer      = smp_valid_i && smp_ready_o;
  assign w_bypass    = w_k0 && !r_hold_full && w_xfer;

`ifdef I2S_REPEAT_ON_UNDERRUN_EN
  logic [FW-1:0] r_last;
  always_ff @(posedge clk_50mhz or negedge rst_ni) begin
    if (!rst_ni)                  r_last <= '0;
    else if (!w_stay)             r_last <= '0;
    else if (w_k0 && !w_underrun) r_last <= w_frame;
  end
`endif

  always_comb begin
    w_underrun = 1'b0;
    if (r_hold_full) begin
      w_frame = pack(r_hold_l, r_hold_r);
    end else if (w_xfer) begin
      w_frame = pack(smp_left_i, smp_right_i);
    end else begin
      w_underrun = 1'b1;
`ifdef I2S_REPEAT_ON_UNDERRUN_EN
      w_frame = r_last;
`else
      w_frame = '0;
`endif
    end
  end

  // Leaving RUN (or sitting in IDLE) parks everything at the RUN-entry values.
  always_ff @(posedge clk_50mhz or negedge rst_ni) begin
    if (!rst_ni) begin
      r_div         <= '0;
      r_k           <= '0;
      r_shift       <= '0;
      r_hold_full   <= 1'b0;
      r_hold_l      <= '0;
      r_hold_r      <= '0;
      aud_bclk_o    <= 1'b0;
      aud_daclrck_o <= 1'b0;
      aud_dacdat_o  <= 1'b0;
      frame_start_o <= 1'b0;
      underrun_o    <= 1'b0;
    end else if (!w_stay) begin
      r_div         <= '0;
      r_k           <= K_LAST;
      r_shift       <= '0;
      r_hold_full   <= 1'b0;
      aud_bclk_o    <= 1'b0;
      aud_daclrck_o <= 1'b0;
      aud_dacdat_o  <= 1'b0;
      frame_start_o <= 1'b0;
      underrun_o    <= 1'b0;
    end else begin
      frame_start_o <= w_k0;
      underrun_o    <= w_k0 && w_underrun;
      if (w_tick) begin
        r_div      <= '0;
        aud_bclk_o <= !aud_bclk_o;
      end else begin
        r_div <= r_div + DW'(1);
      end
      if (w_fall) begin
        r_k           <= w_k_nxt;
        aud_daclrck_o <= (w_k_nxt >= KW'(SLOT_W));
        aud_dacdat_o  <= r_shift[FW-1];
        r_shift       <= w_k0 ? w_frame : {r_shift[FW-2:0], 1'b0};
      end
      if (w_k0 && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (w_xfer && !w_bypass) begin
        r_hold_full <= 1'b1;
        r_hold_l    <= smp_left_i;
        r_hold_r    <= smp_right_i;
      end
    end
  end
endmodule

// File: tb/tb_codec_i2s_dac_tx.sv
// tb/tb_codec_i2s_dac_tx.sv - self-checking bench for codec_i2s_dac_tx (BCLK_DIV=2, 16-bit slots)
module tb_codec_i2s_dac_tx;
  logic        clk = 1'b0;
  logic        rst_n, en, cf_done, smp_valid;
  logic [15:0] smp_l, smp_r;
  logic        smp_ready, bclk, lrck, dacdat, fstart, urun;

  codec_i2s_dac_tx #(.DATA_W(16), .SLOT_W(16), .BCLK_DIV(2)) dut (
    .clk_50mhz(clk), .rst_ni(rst_n), .en_i(en), .cf_done_i(cf_done),
    .smp_valid_i(smp_valid), .smp_ready_o(smp_ready),
    .smp_left_i(smp_l), .smp_right_i(smp_r),
    .aud_bclk_o(bclk), .aud_daclrck_o(lrck), .aud_dacdat_o(dacdat),
    .frame_start_o(fstart), .underrun_o(urun)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [15:0] l; logic [15:0] r; } pair_t;
  typedef struct { logic [15:0] l; logic [15:0] r; logic [31:0] word; logic ur_next; } vec_t;

`ifdef I2S_REPEAT_ON_UNDERRUN_EN
  localparam logic [31:0] UR_WORD = 32'h1234_5678;
`else
  localparam logic [31:0] UR_WORD = 32'h0000_0000;
`endif

  pair_t       q[$];
  pair_t       tmp;
  vec_t        vt[4];
  int          passed = 0, total = 0;
  int          cyc = 0, kk = 31;
  logic        feed_en = 1'b0, pend = 1'b0, prev_bclk = 1'b0, fell = 1'b0;
  logic [31:0] cap = '0, lrw = '0, done_word = '0, done_lr = '0;
  logic        last_ur = 1'b0;
  int          k0_cyc = 0, period = 0, first_fall_cyc = 0, prev_fall_cyc = 0;
  int          fs_bad = 0, ur_bad = 0, gap_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
    else passed++;
  endtask

  // One clock: drive the sample feeder and observe the DUT on the falling clock edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (pend && q.size() > 0) tmp = q.pop_front();
    pend = 1'b0;
    if (feed_en) begin
      if (q.size() > 0) begin
        smp_valid = 1'b1; smp_l = q[0].l; smp_r = q[0].r;
        pend = smp_ready;
      end else begin
        smp_valid = 1'b0;
      end
    end
    fell = prev_bclk && !bclk;
    prev_bclk = bclk;
    if (fell) begin
      kk = (kk == 31) ? 0 : kk + 1;
      if (first_fall_cyc == 0) first_fall_cyc = cyc;
      if (prev_fall_cyc != 0 && cyc - prev_fall_cyc != 4) gap_bad++;
      prev_fall_cyc = cyc;
      if (fstart !== (kk == 0)) fs_bad++;
      if (kk == 0) begin
        cap[0] = dacdat; done_word = cap; done_lr = lrw; lrw[31] = lrck; last_ur = urun;
        if (k0_cyc != 0) period = cyc - k0_cyc;
        k0_cyc = cyc;
      end else begin
        cap[32-kk] = dacdat; lrw[31-kk] = lrck;
        if (urun) ur_bad++;
      end
    end else begin
      if (fstart) fs_bad++;
      if (urun) ur_bad++;
    end
  endtask

  task automatic wait_k(input int target, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      step();
      if (fell && kk == target) ok = 1'b1;
    end
  endtask

  task automatic start_run();
    kk = 31; k0_cyc = 0; first_fall_cyc = 0; prev_fall_cyc = 0;
    cf_done = 1'b1;
  endtask

  initial begin
    logic ok;
    int   raise_cyc, idle_bad;
    vt[0] = '{16'hA5C3, 16'h0F01, 32'hA5C3_0F01, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0000, 32'hFFFF_0000, 1'b0};
    vt[2] = '{16'h8001, 16'h7FFE, 32'h8001_7FFE, 1'b0};
    vt[3] = '{16'h1234, 16'h5678, 32'h1234_5678, 1'b1};

    rst_n = 1'b0; en = 1'b0; cf_done = 1'b0; smp_valid = 1'b0; smp_l = '0; smp_r = '0;
    repeat (3) step();
    check("reset_outputs", {26'd0, smp_ready, bclk, lrck, dacdat, fstart, urun}, 32'd0);
    rst_n = 1'b1;

    en = 1'b1; smp_valid = 1'b1; smp_l = 16'hFFFF; smp_r = 16'hFFFF; idle_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if ({smp_ready, bclk, lrck, dacdat, fstart, urun} != 6'd0) idle_bad++;
    end
    check("idle_without_cfg_done", idle_bad, 0);
    smp_valid = 1'b0;

    foreach (vt[i]) q.push_back('{vt[i].l, vt[i].r});
    feed_en = 1'b1;
    raise_cyc = cyc;
    start_run();
    wait_k(0, ok);
    check("first_k0_reached", ok, 1);
    check("first_fall_delay", first_fall_cyc - raise_cyc, 5);
    check("first_load_no_underrun", last_ur, 0);
    for (int i = 0; i < 4; i++) begin
      wait_k(0, ok);
      check($sformatf("vec%0d_k0", i), ok, 1);
      check($sformatf("vec%0d_dacdat", i), done_word, vt[i].word);
      check($sformatf("vec%0d_lrck", i), done_lr, 32'h0000_FFFF);
      check($sformatf("vec%0d_period", i), period, 128);
      check($sformatf("vec%0d_underrun_next", i), last_ur, vt[i].ur_next);
    end

    wait_k(0, ok);
    check("underrun1_dacdat", done_word, UR_WORD);
    check("underrun2_pulse", last_ur, 1);

    feed_en = 1'b0;
    wait_k(31, ok);
    check("bypass_k31_reached", ok, 1);
    repeat (3) step();
    check("bypass_ready", smp_ready, 1);
    smp_valid = 1'b1; smp_l = 16'h3C5A; smp_r = 16'hC3A5;
    step();
    smp_valid = 1'b0;
    check("bypass_k0_event", {31'd0, fell && kk == 0}, 1);
    check("underrun2_dacdat", done_word, UR_WORD);
    check("bypass_no_underrun", last_ur, 0);
    wait_k(0, ok);
    check("bypass_dacdat", done_word, 32'h3C5A_C3A5);
    check("after_bypass_underrun", last_ur, 1);
    check("frame_start_only_at_k0", fs_bad, 0);
    check("underrun_only_at_k0", ur_bad, 0);
    check("bclk_period_4", gap_bad, 0);

    q.push_back('{16'hDEAD, 16'hBEEF});
    feed_en = 1'b1;
    wait_k(10, ok);
    check("abort_k10_reached", ok, 1);
    cf_done = 1'b0;
    feed_en = 1'b0; smp_valid = 1'b0; q.delete();
    step();
    check("abort_outputs_zero", {26'd0, smp_ready, bclk, lrck, dacdat, fstart, urun}, 32'd0);
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({smp_ready, bclk, lrck, dacdat, fstart, urun} != 6'd0) idle_bad++;
    end
    check("abort_stays_idle", idle_bad, 0);
    raise_cyc = cyc;
    start_run();
    wait_k(0, ok);
    check("restart_k0_reached", ok, 1);
    check("restart_fall_delay", first_fall_cyc - raise_cyc, 5);
    check("restart_frame_start", fstart, 1);
    check("restart_underrun", last_ur, 1);

    q.push_back('{16'h5555, 16'hAAAA});
    feed_en = 1'b1;
    wait_k(20, ok);
    check("rst_k20_reached", ok, 1);
    repeat (2) step();
    check("pre_reset_bclk_lrck", {30'd0, bclk, lrck}, 32'd3);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {26'd0, smp_ready, bclk, lrck, dacdat, fstart, urun}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
